// File: rtl/l2_request_arbiter_if.sv
// L1-facing request/response and L2-facing port bundle of the L2 request arbiter.
// Signal suffixes are from the arbiter's point of view.
interface l2_request_arbiter_if #(
   parameter int unsigned BW_ADDR = 24
);
   logic [1:0]         req_i;
   logic [1:0]         rw_i;
   logic [BW_ADDR-1:0] add0_i;
   logic [BW_ADDR-1:0] add1_i;
   logic [BW_ADDR-1:0] ref_add0_i;
   logic [BW_ADDR-1:0] ref_add1_i;
   logic [31:0]        data0_i;
   logic [31:0]        data1_i;
   logic [1:0]         done_o;
   logic [31:0]        data_o;
   logic               l2_enable_i;
   logic               l2_req_o;
   logic               l2_rw_o;
   logic [BW_ADDR-1:0] l2_add_o;
   logic [BW_ADDR-1:0] l2_ref_add_o;
   logic [31:0]        l2_data_o;
   logic               l2_done_i;
   logic [31:0]        l2_data_i;
   logic [1:0]         grant_o;
   logic               error_o;
   logic [31:0]        gnt_count0_o;
   logic [31:0]        gnt_count1_o;

   modport slave (
      input  req_i, rw_i, add0_i, add1_i, ref_add0_i, ref_add1_i, data0_i, data1_i,
             l2_enable_i, l2_done_i, l2_data_i,
      output done_o, data_o, l2_req_o, l2_rw_o, l2_add_o, l2_ref_add_o, l2_data_o,
             grant_o, error_o, gnt_count0_o, gnt_count1_o
   );

   modport master (
      output req_i, rw_i, add0_i, add1_i, ref_add0_i, ref_add1_i, data0_i, data1_i,
             l2_enable_i, l2_done_i, l2_data_i,
      input  done_o, data_o, l2_req_o, l2_rw_o, l2_add_o, l2_ref_add_o, l2_data_o,
             grant_o, error_o, gnt_count0_o, gnt_count1_o
   );
endinterface

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing the L2 port between L1I (0) and L1D (1); one outstanding
// transaction, registered outputs, sticky watchdog flag and per-requester grant counters.
module l2_request_arbiter #(
   parameter int unsigned BW_ADDR        = 24,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                 clock_i,
   input logic                 reset_i,
   l2_request_arbiter_if.slave bus
);
   localparam int unsigned WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HOLD} state_t;

   state_t             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic [1:0]         grant_q, grant_d;
   logic [1:0]         done_q, done_d;
   logic               l2_req_q, l2_req_d;
   logic               rw_q, rw_d;
   logic               error_q, error_d;
   logic [BW_ADDR-1:0] add_q, add_d;
   logic [BW_ADDR-1:0] ref_q, ref_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [31:0]        cnt0_q, cnt0_d;
   logic [31:0]        cnt1_q, cnt1_d;
   logic [WDW-1:0]     wd_q, wd_d;
   logic               grant_ok;
   logic               win;

   assign grant_ok = bus.l2_enable_i && (bus.req_i != 2'b00);
   // Requester 1 wins when alone, or on contention when requester 0 was served last.
   assign win      = bus.req_i[1] && (!bus.req_i[0] || !last_grant_q);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= '0;
         done_q       <= '0;
         l2_req_q     <= 1'b0;
         rw_q         <= 1'b0;
         error_q      <= 1'b0;
         add_q        <= '0;
         ref_q        <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
         wd_q         <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         done_q       <= done_d;
         l2_req_q     <= l2_req_d;
         rw_q         <= rw_d;
         error_q      <= error_d;
         add_q        <= add_d;
         ref_q        <= ref_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
         wd_q         <= wd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant_ok) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (bus.l2_done_i) state_d = RESP;
         RESP:    state_d = HOLD;
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      done_d       = '0;
      l2_req_d     = 1'b0;
      rw_d         = rw_q;
      error_d      = error_q;
      add_d        = add_q;
      ref_d        = ref_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      wd_d         = wd_q;
      unique case (state_q)
         IDLE: begin
            if (grant_ok) begin
               l2_req_d = 1'b1;
               grant_d  = win ? 2'b10 : 2'b01;
               rw_d     = bus.rw_i[win];
               add_d    = win ? bus.add1_i : bus.add0_i;
               ref_d    = win ? bus.ref_add1_i : bus.ref_add0_i;
               wdata_d  = win ? bus.data1_i : bus.data0_i;
               if (win) cnt1_d = cnt1_q + 32'd1;
               else     cnt0_d = cnt0_q + 32'd1;
            end
         end
         ISSUE: wd_d = '0;
         WAIT: begin
            if (bus.l2_done_i) begin
               rdata_d = bus.l2_data_i;
               done_d  = grant_q;
            end else begin
               wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
               if ((TIMEOUT_CYCLES != 0) && (wd_d == WD_MAX)) error_d = 1'b1;
            end
         end
         RESP: begin
            last_grant_d = grant_q[1];
            grant_d      = '0;
         end
         default: ;
      endcase
   end

   assign bus.done_o       = done_q;
   assign bus.data_o       = rdata_q;
   assign bus.l2_req_o     = l2_req_q;
   assign bus.l2_rw_o      = rw_q;
   assign bus.l2_add_o     = add_q;
   assign bus.l2_ref_add_o = ref_q;
   assign bus.l2_data_o    = wdata_q;
   assign bus.grant_o      = grant_q;
   assign bus.error_o      = error_q;
   assign bus.gnt_count0_o = cnt0_q;
   assign bus.gnt_count1_o = cnt1_q;
endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: cycle table for single transactions plus
// hand-written fairness, watchdog and mid-transaction reset sequences.
module tb_l2_request_arbiter;
   localparam int unsigned AW = 24;
   localparam logic [AW-1:0] ADD0  = 24'h000100;
   localparam logic [AW-1:0] REF0  = 24'h400000;
   localparam logic [AW-1:0] ADD1  = 24'h0000A4;
   localparam logic [AW-1:0] REF1  = 24'h400040;
   localparam logic [31:0]   DATA0 = 32'h11111111;
   localparam logic [31:0]   DATA1 = 32'h12345678;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;

   l2_request_arbiter_if #(.BW_ADDR(AW)) bus ();

   l2_request_arbiter #(.BW_ADDR(AW), .TIMEOUT_CYCLES(8)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic [1:0]  rw;
      logic        en;
      logic        l2d;
      logic [31:0] l2data;
      logic        e_l2req;
      logic [1:0]  e_grant;
      logic [1:0]  e_done;
      logic [31:0] e_data;
      logic        e_rw;
      logic [31:0] e_cnt0;
      logic [31:0] e_cnt1;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic vec(input logic r, input logic [1:0] rq, input logic [1:0] w, input logic en,
                      input logic d, input logic [31:0] dd, input logic el2, input logic [1:0] eg,
                      input logic [1:0] edn, input logic [31:0] ed, input logic erw,
                      input logic [31:0] c0, input logic [31:0] c1);
      vec_t v;
      v.rst = r; v.req = rq; v.rw = w; v.en = en; v.l2d = d; v.l2data = dd;
      v.e_l2req = el2; v.e_grant = eg; v.e_done = edn; v.e_data = ed; v.e_rw = erw;
      v.e_cnt0 = c0; v.e_cnt1 = c1;
      tbl.push_back(v);
   endtask

   initial begin
      int last_c;
      logic [1:0] eg;

      // Each row: inputs before an edge, expected outputs just after it.
      vec(1, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
      // L1I read, L2 answers 3 cycles after l2_req_o
      vec(0, 2'b01, 2'b00, 1, 0, 0, 1, 2'b01, 2'b00, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) vec(0, 2'b01, 2'b00, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0);
      vec(0, 2'b01, 2'b00, 1, 1, 32'hDEADBEEF, 0, 2'b01, 2'b01, 32'hDEADBEEF, 0, 1, 0);
      vec(0, 2'b01, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
      vec(0, 2'b01, 2'b00, 1, 1, 32'hBAD0BAD0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
      vec(0, 2'b00, 2'b00, 1, 1, 32'hBAD0BAD0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
      // L2 disabled: no grant until enable returns; dropping enable later does not cancel
      for (int i = 0; i < 10; i++) vec(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0);
      vec(0, 2'b01, 2'b00, 1, 0, 0, 1, 2'b01, 2'b00, 0, 0, 2, 0);
      vec(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 2, 0);
      vec(0, 2'b01, 2'b00, 0, 1, 32'h0000CAFE, 0, 2'b01, 2'b01, 32'h0000CAFE, 0, 2, 0);
      vec(0, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2, 0);
      vec(0, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2, 0);
      // L1D write, latched outputs must hold through WAIT
      vec(0, 2'b10, 2'b10, 1, 0, 0, 1, 2'b10, 2'b00, 0, 1, 2, 1);
      for (int i = 0; i < 3; i++) vec(0, 2'b10, 2'b10, 1, 0, 0, 0, 2'b10, 2'b00, 0, 1, 2, 1);
      vec(0, 2'b10, 2'b10, 1, 1, 32'hA5A50001, 0, 2'b10, 2'b10, 32'hA5A50001, 1, 2, 1);
      vec(0, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2, 1);
      vec(0, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2, 1);

      bus.add0_i = ADD0; bus.ref_add0_i = REF0; bus.data0_i = DATA0;
      bus.add1_i = ADD1; bus.ref_add1_i = REF1; bus.data1_i = DATA1;
      bus.l2_data_i = '0; bus.l2_done_i = 1'b0; bus.l2_enable_i = 1'b1;
      bus.req_i = '0; bus.rw_i = '0; rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         vec_t v;
         v = tbl[i];
         rst = v.rst; bus.req_i = v.req; bus.rw_i = v.rw; bus.l2_enable_i = v.en;
         bus.l2_done_i = v.l2d; bus.l2_data_i = v.l2data;
         tick();
         chk($sformatf("row%0d_ctl(l2req,grant,done,err)", i),
             {bus.l2_req_o, bus.grant_o, bus.done_o, bus.error_o},
             {v.e_l2req, v.e_grant, v.e_done, 1'b0});
         chk($sformatf("row%0d_counts", i), {bus.gnt_count0_o, bus.gnt_count1_o},
             {v.e_cnt0, v.e_cnt1});
         if (v.e_done != 2'b00 || v.rst) chk($sformatf("row%0d_data", i), bus.data_o, v.e_data);
         if (v.rst) begin
            chk("reset_l2_regs", {bus.l2_rw_o, bus.l2_add_o, bus.l2_ref_add_o, bus.l2_data_o}, '0);
         end else if (v.e_grant != 2'b00) begin
            chk($sformatf("row%0d_l2_rw_add_ref", i), {bus.l2_rw_o, bus.l2_add_o, bus.l2_ref_add_o},
                {v.e_rw, v.e_grant[1] ? ADD1 : ADD0, v.e_grant[1] ? REF1 : REF0});
            chk($sformatf("row%0d_l2_data", i), bus.l2_data_o, v.e_grant[1] ? DATA1 : DATA0);
         end
      end

      // Fairness: both requesting continuously from reset
      rst = 1'b1; bus.req_i = 2'b00; bus.l2_done_i = 1'b0; bus.l2_enable_i = 1'b1;
      tick();
      rst = 1'b0; bus.req_i = 2'b11; bus.rw_i = 2'b00;
      last_c = 0;
      for (int i = 0; i < 6; i++) begin
         int n;
         n = 0;
         while (bus.l2_req_o !== 1'b1 && n < 50) begin
            tick();
            n++;
         end
         if (n >= 50) begin
            chk("fair_wait_l2_req", 0, 1);
            break;
         end
         eg = (i % 2 == 1) ? 2'b10 : 2'b01;
         chk($sformatf("fair_grant%0d", i), bus.grant_o, eg);
         if (i > 0) chk($sformatf("fair_interval%0d", i), cyc - last_c, 5);
         last_c = cyc;
         tick();
         bus.l2_done_i = 1'b1; bus.l2_data_i = 32'hF0000000 + i;
         tick();
         chk($sformatf("fair_done%0d", i), bus.done_o, eg);
         chk($sformatf("fair_data%0d", i), bus.data_o, 32'hF0000000 + i);
         bus.l2_done_i = 1'b0;
      end
      chk("fair_counts", {bus.gnt_count0_o, bus.gnt_count1_o}, {32'd3, 32'd3});

      // Watchdog: done withheld for 20 WAIT cycles
      bus.req_i = 2'b00;
      tick(); tick();
      bus.req_i = 2'b01;
      tick();
      chk("wd_issue", {bus.l2_req_o, bus.grant_o, bus.error_o}, {1'b1, 2'b01, 1'b0});
      tick();
      for (int j = 0; j < 7; j++) tick();
      chk("wd_before_limit", bus.error_o, 1'b0);
      tick();
      chk("wd_at_limit", bus.error_o, 1'b1);
      for (int j = 0; j < 12; j++) tick();
      chk("wd_still_waiting", {bus.error_o, bus.l2_req_o, bus.done_o, bus.grant_o},
          {1'b1, 1'b0, 2'b00, 2'b01});
      bus.l2_done_i = 1'b1; bus.l2_data_i = 32'h5A5A5A5A;
      tick();
      chk("wd_late_done", {bus.done_o, bus.data_o}, {2'b01, 32'h5A5A5A5A});
      bus.l2_done_i = 1'b0; bus.req_i = 2'b00;
      tick();
      chk("wd_sticky", {bus.error_o, bus.grant_o, bus.done_o}, {1'b1, 2'b00, 2'b00});
      tick();

      // Reset during WAIT, then contention must favour requester 0
      bus.req_i = 2'b01;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("rst_wait_ctl", {bus.l2_req_o, bus.grant_o, bus.done_o, bus.error_o}, '0);
      chk("rst_wait_l2", {bus.l2_rw_o, bus.l2_add_o, bus.l2_ref_add_o}, '0);
      chk("rst_wait_data", {bus.l2_data_o, bus.data_o}, '0);
      chk("rst_wait_counts", {bus.gnt_count0_o, bus.gnt_count1_o}, '0);
      rst = 1'b0; bus.req_i = 2'b11;
      tick();
      chk("rst_then_prio0", {bus.l2_req_o, bus.grant_o, bus.gnt_count0_o}, {1'b1, 2'b01, 32'd1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
- Shares the single L1-facing port of the L2 cache between the L1 instruction cache (requester 0) and the L1 data cache (requester 1).
- Uses round-robin arbitration and allows one outstanding L2 transaction at a time.
- Latches the granted request, issues a one-cycle request to the L2 controller, waits for L2 done, and returns data and a done pulse to the granted requester.
- Provides a watchdog error flag and per-requester grant counters for performance monitoring.

Parameters:
- BW_ADDR, 24: word-address width; equals `BW_WORD_ADDR in this build.
- TIMEOUT_CYCLES, 1024: maximum WAIT cycles before error_o sets; 0 disables the watchdog.

Ports:
- clock_i  in  1  controller clock (180deg phase of the cache clock bus)
- reset_i  in  1  synchronous active-high reset
- req_i  in  2  per-requester level request; bit0 = L1I, bit1 = L1D
- rw_i  in  2  per-requester 1 = write, 0 = read
- add0_i / add1_i  in  BW_ADDR  request word address
- ref_add0_i / ref_add1_i  in  BW_ADDR  PC of the referencing instruction
- data0_i / data1_i  in  32  write data
- done_o  out  2  one-cycle completion pulse to the granted requester
- data_o  out  32  read data; valid while done_o is nonzero
- l2_enable_i  in  1  L2 may accept requests (inverse of CPC stall)
- l2_req_o  out  1  one-cycle request to L2
- l2_rw_o  out  1  latched rw
- l2_add_o  out  BW_ADDR  latched address
- l2_ref_add_o  out  BW_ADDR  latched reference address
- l2_data_o  out  32  latched write data
- l2_done_i  in  1  L2 transaction complete
- l2_data_i  in  32  L2 read data; valid with l2_done_i
- grant_o  out  2  one-hot current owner; 0 when idle
- error_o  out  1  sticky watchdog flag
- gnt_count0_o / gnt_count1_o  out  32  grants issued per requester

Behaviour:
- Reset (synchronous, reset_i = 1 at a clock_i edge):
  - state -> IDLE; all outputs 0; counters 0; error_o 0.
  - Round-robin pointer last_grant -> 1, so requester 0 has priority on the first contention.
  - Reset mid-transaction abandons the transaction with no done_o pulse; the L2 is reset in the same cycle.
- Requester contract:
  - Hold req_i, rw, address, ref address and data stable until done_o is seen.
  - Deassert req_i within one cycle after done_o.
- State machine (all outputs registered):
  - IDLE:
    - If l2_enable_i = 1 and any req_i bit is set, pick the winner. If only one bit is set, that requester wins. If both are set, the requester != last_grant wins.
    - Latch the winner's rw, add, ref_add and data into the l2_* registers; set grant_o one-hot; increment the winner's gnt_count (wraps at 2^32); go to ISSUE.
    - If l2_enable_i = 0, no grant is made and the state stays IDLE.
  - ISSUE: l2_req_o = 1 for exactly this cycle; clear the watchdog counter; go to WAIT.
  - WAIT:
    - l2_req_o = 0; l2_rw_o, l2_add_o, l2_ref_add_o and l2_data_o stay stable.
    - On l2_done_i = 1: capture l2_data_i into data_o, set done_o[owner] = 1, go to RESP.
    - Otherwise increment the watchdog counter, saturating at TIMEOUT_CYCLES.
    - When the counter equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), set error_o = 1 and keep waiting; the transaction is never abandoned.
  - RESP: done_o asserted for exactly this cycle; last_grant <- owner; go to HOLD.
  - HOLD: done_o = 0, grant_o = 0, req_i ignored for this cycle, which absorbs the requester's deassertion latency; go to IDLE.
- Latency:
  - Uncontended, with l2_done_i arriving k cycles after l2_req_o: req_i sampled at edge N -> l2_req_o high in cycle N+1 -> done_o high k+1 cycles after l2_req_o.
  - Minimum initiation interval between grants is 4 cycles + L2 latency.
- Simultaneous events:
  - l2_done_i outside WAIT is ignored.
  - A req_i edge arriving during ISSUE/WAIT/RESP/HOLD waits for IDLE.
  - l2_enable_i dropping after the grant does not cancel the transaction.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1...
- error_o clears only on reset.

Test Plan:
- Single L1I read, L2 responds 3 cycles after l2_req_o with 0xDEADBEEF -> l2_req_o high 1 cycle, l2_add_o = add0_i, done_o = 2'b01 for 1 cycle with data_o = 0xDEADBEEF, gnt_count0_o = 1.
- Both req_i = 2'b11 from reset, held continuously for 6 transactions -> grant sequence 0,1,0,1,0,1; gnt_count0_o = gnt_count1_o = 3.
- L1D write of 0x12345678 to 0x0000A4 -> l2_rw_o = 1, l2_data_o = 0x12345678; outputs stable through WAIT; done_o = 2'b10.
- l2_enable_i = 0 with req_i = 2'b01 for 10 cycles -> no l2_req_o and grant_o = 0; enable -> grant on the next edge.
- TIMEOUT_CYCLES = 8 with l2_done_i withheld for 20 cycles -> error_o sets after 8 WAIT cycles and stays 1; a late l2_done_i still completes with done_o.
- reset_i asserted during WAIT -> the next cycle shows all outputs 0 and IDLE; a subsequent contention grants requester 0 first.
